// File: rtl/adma_xfer_engine_if.sv
// RAM/FIFO side bus of the ADMA transfer engine.
// Latency: none, plain wires.
// Backpressure: carried by fifo_empty / fifo_full from the FIFO side.
interface adma_xfer_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 64
);
  localparam int BYTES = DATA_W / 8;

  // RAM port
  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_address;
  logic [BYTES-1:0]  ram_byte_en;
  logic [DATA_W-1:0] data_from_ram;
  logic [DATA_W-1:0] data_to_ram;

  // SD data FIFO port (first-word-fall-through)
  logic              fifo_read;
  logic              fifo_write;
  logic [DATA_W-1:0] data_from_fifo;
  logic [DATA_W-1:0] data_to_fifo;
  logic              fifo_empty;
  logic              fifo_full;

  // Engine side
  modport master (
    output ram_read, ram_write, ram_address, ram_byte_en, data_to_ram,
    output fifo_read, fifo_write, data_to_fifo,
    input  data_from_ram, data_from_fifo, fifo_empty, fifo_full
  );

  // RAM / FIFO side
  modport slave (
    input  ram_read, ram_write, ram_address, ram_byte_en, data_to_ram,
    input  fifo_read, fifo_write, data_to_fifo,
    output data_from_ram, data_from_fifo, fifo_empty, fifo_full
  );
endinterface

// File: rtl/adma_xfer_engine.sv
// Moves one ADMA descriptor of data between system RAM and the SD data FIFO, one beat per cycle.
// Latency: first beat in the cycle after start; TFC one cycle after the last beat.
// Backpressure: fifo_empty / fifo_full park the engine in a WAIT state; it resumes one cycle after the flag clears.
// Optional stall timeout (WAIT -> ERROR) is built when ADMA_XFER_TIMEOUT_EN is defined.
module adma_xfer_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16,
  parameter int TMO_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              direction,
  input  logic              abort,
  input  logic [ADDR_W-1:0] address_init,
  input  logic [LEN_W-1:0]  length,
  input  logic [TMO_W-1:0]  timeout_limit,
  output logic              TFC,
  output logic              busy,
  output logic              error_timeout,
  adma_xfer_engine_if.master bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  // One extra bit: length 0 encodes 2^LEN_W bytes
  localparam int CNT_W = LEN_W + 1;
  localparam int LB_W  = OFF_W + 1;

  typedef enum logic [6:0] {
    S_IDLE       = 7'b0000001,
    S_FIFO_RAM   = 7'b0000010,
    S_RAM_FIFO   = 7'b0000100,
    S_WAIT_READ  = 7'b0001000,
    S_WAIT_WRITE = 7'b0010000,
    S_DONE       = 7'b0100000,
    S_ERROR      = 7'b1000000
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic [LB_W-1:0]   last_bytes_q, last_bytes_d;
  logic              tfc_q, tfc_d;
  logic              busy_q, busy_d;

`ifdef ADMA_XFER_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_limit_q, tmo_limit_d;
  logic [TMO_W-1:0]  stall_q, stall_d;
  logic              err_q, err_d;
`else
  // Timeout limit has no consumer when the stall counter is not built
  logic              unused_tmo;
  assign unused_tmo = ^timeout_limit;
`endif

  // Launch-time decode of the descriptor length
  logic [CNT_W-1:0]  len_full;
  logic [CNT_W-1:0]  len_rem;
  logic [CNT_W-1:0]  beats_init;
  logic [LB_W-1:0]   last_bytes_init;
  logic [ADDR_W-1:0] addr_init_al;

  // Beat issue qualifiers; abort suppresses any beat in its cycle
  logic              wr_go;
  logic              rd_go;
  logic              last_beat;
  logic [BYTES-1:0]  tail_mask;

  // Decode length into beat count and valid bytes of the final beat
  always_comb begin
    len_full        = (length == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, length};
    len_rem         = len_full & CNT_W'(BYTES - 1);
    beats_init      = (len_full + CNT_W'(BYTES - 1)) >> OFF_W;
    last_bytes_init = (len_rem == '0) ? LB_W'(BYTES) : LB_W'(len_rem);
    addr_init_al    = address_init & ~ADDR_W'(BYTES - 1);
  end

  // Beat strobes and byte-enable mask for the current beat
  always_comb begin
    wr_go     = (state_q == S_FIFO_RAM) && !bus.fifo_empty && !abort;
    rd_go     = (state_q == S_RAM_FIFO) && !bus.fifo_full  && !abort;
    last_beat = (beats_q == CNT_W'(1));
    tail_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      tail_mask[i] = (i < int'(last_bytes_q));
    end
  end

  // Datapath: strobes and data are combinational, address comes straight from the flop
  always_comb begin
    bus.ram_write    = wr_go;
    bus.fifo_read    = wr_go;
    bus.ram_read     = rd_go;
    bus.fifo_write   = rd_go;
    bus.data_to_ram  = wr_go ? bus.data_from_fifo : '0;
    bus.data_to_fifo = rd_go ? bus.data_from_ram  : '0;
    bus.ram_address  = addr_q;
    // RAM->FIFO pushes a full word on the tail beat; the FIFO consumer trims it
    if (wr_go) begin
      bus.ram_byte_en = last_beat ? tail_mask : {BYTES{1'b1}};
    end else begin
      bus.ram_byte_en = '0;
    end
  end

  // Next-state and counter update for the transfer FSM
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_d      = beats_q;
    last_bytes_d = last_bytes_q;
`ifdef ADMA_XFER_TIMEOUT_EN
    tmo_limit_d  = tmo_limit_q;
    stall_d      = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d       = addr_init_al;
          beats_d      = beats_init;
          last_bytes_d = last_bytes_init;
`ifdef ADMA_XFER_TIMEOUT_EN
          tmo_limit_d  = timeout_limit;
`endif
          state_d      = direction ? S_RAM_FIFO : S_FIFO_RAM;
        end
      end

      S_FIFO_RAM, S_RAM_FIFO: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (wr_go || rd_go) begin
          addr_d  = addr_q + ADDR_W'(BYTES);
          beats_d = beats_q - CNT_W'(1);
          if (last_beat) begin
            state_d = S_DONE;
          end
        end else begin
          state_d = (state_q == S_FIFO_RAM) ? S_WAIT_READ : S_WAIT_WRITE;
        end
      end

      S_WAIT_READ, S_WAIT_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if ((state_q == S_WAIT_READ) ? !bus.fifo_empty : !bus.fifo_full) begin
          state_d = (state_q == S_WAIT_READ) ? S_FIFO_RAM : S_RAM_FIFO;
        end else begin
`ifdef ADMA_XFER_TIMEOUT_EN
          stall_d = stall_q + TMO_W'(1);
          // A zero limit disables the timeout
          if ((tmo_limit_q != '0) && (stall_d == tmo_limit_q)) begin
            state_d = S_ERROR;
          end
`endif
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered images of the state being entered
    tfc_d  = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
`ifdef ADMA_XFER_TIMEOUT_EN
    err_d  = (state_d == S_ERROR);
`endif
  end

  // State and counter registers; reset overrides everything
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      beats_q      <= '0;
      last_bytes_q <= '0;
      tfc_q        <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ADMA_XFER_TIMEOUT_EN
      tmo_limit_q  <= '0;
      stall_q      <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_q      <= beats_d;
      last_bytes_q <= last_bytes_d;
      tfc_q        <= tfc_d;
      busy_q       <= busy_d;
`ifdef ADMA_XFER_TIMEOUT_EN
      tmo_limit_q  <= tmo_limit_d;
      stall_q      <= stall_d;
      err_q        <= err_d;
`endif
    end
  end

  assign TFC  = tfc_q;
  assign busy = busy_q;
`ifdef ADMA_XFER_TIMEOUT_EN
  assign error_timeout = err_q;
`else
  assign error_timeout = 1'b0;
`endif

endmodule
